dco_fll_ctrl: RTL and testbench

Frequency-lock controller for the 8-bit DCO. It measures a divided DCO feedback signal against a reference window counted in clk cycles. It then sets dco_code with an 8-step successive-approximation (SAR) search and, optionally, continuous ±1 tracking. It sits between the top-level control inputs and the DCO code input, replacing a static dco_code drive.

---
 rtl/dco_fll_pkg.sv | 21 ++
 rtl/dco_fll_ctrl_if.sv | 31 +++
 rtl/dco_edge_counter.sv | 44 ++++
 rtl/dco_fll_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dco_fll_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dco_fll_pkg.sv
// Shared types and default sizes for the DCO frequency-lock controller.
package dco_fll_pkg;

  localparam int unsigned DefaultCodeW     = 8;
  localparam int unsigned DefaultCntW      = 16;
  localparam int unsigned DefaultWinW      = 16;
  localparam int unsigned DefaultSettleCyc = 32;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StMeasure,
    StDecide
  } fll_state_e;

  typedef enum logic {
    PhSar,
    PhTrack
  } fll_phase_e;

endpackage

// File: rtl/dco_fll_ctrl_if.sv
// Control/status bundle between the system side and the DCO frequency-lock controller.
interface dco_fll_ctrl_if import dco_fll_pkg::*; #(
  parameter int unsigned CODE_W = DefaultCodeW,
  parameter int unsigned CNT_W  = DefaultCntW,
  parameter int unsigned WIN_W  = DefaultWinW
);

  logic              start;
  logic              track_en;
  logic [CNT_W-1:0]  target_cnt;
  logic [7:0]        tol;
  logic [WIN_W-1:0]  win_len;
  logic              dco_fb;
  logic [CODE_W-1:0] dco_code;
  logic [CNT_W-1:0]  meas_cnt;
  logic              busy;
  logic              done;
  logic              locked;
  logic              sat;

  modport master (
    output start, track_en, target_cnt, tol, win_len, dco_fb,
    input  dco_code, meas_cnt, busy, done, locked, sat
  );

  modport slave (
    input  start, track_en, target_cnt, tol, win_len, dco_fb,
    output dco_code, meas_cnt, busy, done, locked, sat
  );

endinterface

// File: rtl/dco_edge_counter.sv
// Synchronises the divided DCO feedback, detects rising edges and counts them with saturation.
module dco_edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dco_fb_i,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [CNT_W-1:0] count_o
);

  logic             sync1_q, sync2_q, prev_q;
  logic             edge_seen;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign edge_seen = sync2_q & ~prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (enable_i && edge_seen && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Expose the running total including this cycle's edge so a load on the
  // last window cycle captures the whole window.
  assign count_o = cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= dco_fb_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= clear_i ? '0 : cnt_d;
    end
  end

endmodule

// File: rtl/dco_fll_ctrl.sv
// DCO frequency-lock controller: SAR search over the DCO code, then optional +/-1 tracking
// against an edge count measured over a clk-cycle window.
module dco_fll_ctrl import dco_fll_pkg::*; #(
  parameter int unsigned CODE_W     = DefaultCodeW,
  parameter int unsigned CNT_W      = DefaultCntW,
  parameter int unsigned WIN_W      = DefaultWinW,
  parameter int unsigned SETTLE_CYC = DefaultSettleCyc
) (
  input logic           clk,
  input logic           rst,
  dco_fll_ctrl_if.slave bus
);

  localparam int unsigned      IdxW       = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int unsigned      ExtW       = CNT_W + 1;
  localparam logic [WIN_W-1:0] SettleLast = WIN_W'(SETTLE_CYC - 1);
  localparam logic [IdxW-1:0]  IdxTop     = IdxW'(CODE_W - 1);

  fll_state_e        state_q, state_d;
  fll_phase_e        phase_q, phase_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIN_W-1:0]  tmr_q, tmr_d;
  logic [WIN_W-1:0]  win_last;
  logic [CNT_W-1:0]  meas_q, meas_d;
  logic [CNT_W-1:0]  win_count;
  logic              locked_q, locked_d;
  logic              sat_q, sat_d;
  logic              done_pulse;
  logic              cnt_en, cnt_clear;
  logic [ExtW-1:0]   meas_ext, band_hi, band_lo;

  assign cnt_en    = (state_q == StMeasure);
  assign cnt_clear = ~cnt_en;

  dco_edge_counter #(
    .CNT_W(CNT_W)
  ) u_edge_counter (
    .clk      (clk),
    .rst      (rst),
    .dco_fb_i (bus.dco_fb),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .count_o  (win_count)
  );

  // A zero window length behaves as a one-cycle window.
  assign win_last = (bus.win_len == '0) ? '0 : bus.win_len - 1'b1;

  // Dead-band in one extra bit so target+tol cannot wrap and the low edge clamps at zero.
  assign meas_ext = {1'b0, meas_q};
  assign band_hi  = {1'b0, bus.target_cnt} + ExtW'(bus.tol);
  assign band_lo  = ({1'b0, bus.target_cnt} > ExtW'(bus.tol)) ?
                    ({1'b0, bus.target_cnt} - ExtW'(bus.tol)) : '0;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    code_d     = code_q;
    idx_d      = idx_q;
    tmr_d      = tmr_q;
    meas_d     = meas_q;
    locked_d   = locked_q;
    sat_d      = sat_q;
    done_pulse = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d            = StSettle;
          phase_d            = PhSar;
          code_d             = '0;
          code_d[CODE_W-1]   = 1'b1;
          idx_d              = IdxTop;
          tmr_d              = '0;
          locked_d           = 1'b0;
          sat_d              = 1'b0;
        end
      end

      StSettle: begin
        if (tmr_q == SettleLast) begin
          state_d = StMeasure;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      StMeasure: begin
        if (tmr_q == win_last) begin
          state_d = StDecide;
          tmr_d   = '0;
          meas_d  = win_count;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      StDecide: begin
        if (phase_q == PhSar) begin
          if (meas_q > bus.target_cnt) begin
            code_d[idx_q] = 1'b0;
          end
          if (idx_q != '0) begin
            code_d[idx_q - 1'b1] = 1'b1;
            idx_d                = idx_q - 1'b1;
            state_d              = StSettle;
          end else begin
            done_pulse = 1'b1;
            if (bus.track_en) begin
              phase_d = PhTrack;
              state_d = StSettle;
            end else begin
              state_d = StIdle;
            end
          end
        end else if (!bus.track_en) begin
          state_d = StIdle;
        end else begin
          state_d = StSettle;
          if (meas_ext > band_hi) begin
            locked_d = 1'b0;
            if (code_q == '0) begin
              sat_d = 1'b1;
            end else begin
              code_d = code_q - 1'b1;
              sat_d  = 1'b0;
            end
          end else if (meas_ext < band_lo) begin
            locked_d = 1'b0;
            if (code_q == '1) begin
              sat_d = 1'b1;
            end else begin
              code_d = code_q + 1'b1;
              sat_d  = 1'b0;
            end
          end else begin
            locked_d = 1'b1;
            sat_d    = 1'b0;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      phase_q  <= PhSar;
      code_q   <= '0;
      idx_q    <= '0;
      tmr_q    <= '0;
      meas_q   <= '0;
      locked_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      tmr_q    <= tmr_d;
      meas_q   <= meas_d;
      locked_q <= locked_d;
      sat_q    <= sat_d;
    end
  end

  assign bus.dco_code = code_q;
  assign bus.meas_cnt = meas_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_pulse;
  assign bus.locked   = locked_q;
  assign bus.sat      = sat_q;

endmodule

// File: tb/tb_dco_fll_ctrl.sv
// Directed bench for dco_fll_ctrl with a phase-accumulator DCO giving (code+offset) rising
// edges per win_len-cycle window.
module tb_dco_fll_ctrl;

  localparam int unsigned CodeW     = 8;
  localparam int unsigned CntW      = 16;
  localparam int unsigned WinW      = 16;
  localparam int unsigned SettleCyc = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         errors = 0;
  int         model_offset = 0;
  int         acc = 0;
  logic [7:0] sar_trial [8];

  dco_fll_ctrl_if #(.CODE_W(CodeW), .CNT_W(CntW), .WIN_W(WinW)) bus ();

  dco_fll_ctrl #(
    .CODE_W     (CodeW),
    .CNT_W      (CntW),
    .WIN_W      (WinW),
    .SETTLE_CYC (SettleCyc)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Plant model: modulus equals the window, so every full window holds exactly rate edges.
  always @(negedge clk) begin : dco_model
    int modv;
    int rate;
    int nxt;
    modv = (bus.win_len == '0) ? 2 : int'(bus.win_len);
    rate = int'(bus.dco_code) + model_offset;
    if (rate < 0) rate = 0;
    nxt = (acc + rate) % modv;
    acc <= nxt;
    bus.dco_fb <= (nxt >= modv / 2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input int w, input int target, input int tolv, input logic trk,
                           input int offs);
    bus.win_len    = WinW'(w);
    bus.target_cnt = CntW'(target);
    bus.tol        = 8'(tolv);
    bus.track_en   = trk;
    bus.start      = 1'b0;
    model_offset   = offs;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    configure(2048, 100, 1, 1'b0, 0);
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.dco_code !== 8'h00) begin
      errors++; $display("FAIL reset_code: got %h expected 00", bus.dco_code);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++; $display("FAIL reset_locked: got %b expected 0", bus.locked);
    end
    checks++;
    if (bus.sat !== 1'b0) begin
      errors++; $display("FAIL reset_sat: got %b expected 0", bus.sat);
    end
    checks++;
    if (bus.meas_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_meas: got %0d expected 0", bus.meas_cnt);
    end
    rst = 1'b0;
  endtask

  // Full SAR towards target 100 with track_en=0; optionally pulses start at cycle inject_at.
  task automatic run_sar(input string tag, input int w, input int inject_at);
    int step;
    int done_cnt;
    int done_at;
    step     = SettleCyc + w + 1;
    done_cnt = 0;
    done_at  = -1;
    pulse_start();
    for (int cyc = 1; cyc <= 8 * step + 1; cyc++) begin
      bus.start = (cyc == inject_at);
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_at = cyc;
      end
      if ((cyc % step == 1) && (cyc / step < 8)) begin
        checks++;
        if (bus.dco_code !== sar_trial[cyc / step]) begin
          errors++;
          $display("FAIL %s_trial%0d: got %h expected %h", tag, cyc / step, bus.dco_code,
                   sar_trial[cyc / step]);
        end
      end
      if (cyc % step == 0) begin
        checks++;
        if (bus.meas_cnt !== CntW'(sar_trial[cyc / step - 1])) begin
          errors++;
          $display("FAIL %s_meas%0d: got %0d expected %0d", tag, cyc / step - 1, bus.meas_cnt,
                   sar_trial[cyc / step - 1]);
        end
      end
      tick();
    end
    bus.start = 1'b0;
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL %s_done_count: got %0d expected 1", tag, done_cnt);
    end
    checks++;
    if (done_at != 8 * step) begin
      errors++; $display("FAIL %s_done_cycle: got %0d expected %0d", tag, done_at, 8 * step);
    end
    checks++;
    if (bus.dco_code !== 8'h64) begin
      errors++; $display("FAIL %s_final_code: got %h expected 64", tag, bus.dco_code);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s_idle_busy: got %b expected 0", tag, bus.busy);
    end
  endtask

  task automatic test_sar_only();
    configure(2048, 100, 1, 1'b0, 0);
    apply_reset();
    run_sar("sar", 2048, 0);
  endtask

  task automatic test_tracking();
    int         step;
    logic [7:0] exp_code;
    logic       exp_lock;
    int         cnt;
    step = SettleCyc + 512 + 1;
    configure(512, 100, 1, 1'b1, 0);
    apply_reset();
    pulse_start();
    repeat (8 * step - 1) tick();
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL track_sar_done: got %b expected 1", bus.done);
    end
    tick();
    checks++;
    if (bus.dco_code !== 8'h64 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL track_enter: got code %h busy %b expected 64/1", bus.dco_code, bus.busy);
    end
    repeat (2 * step) tick();
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++; $display("FAIL track_lock: got %b expected 1", bus.locked);
    end
    checks++;
    if (bus.dco_code !== 8'h64) begin
      errors++; $display("FAIL track_lock_code: got %h expected 64", bus.dco_code);
    end
    model_offset = 10;
    exp_code = 8'd100;
    exp_lock = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      repeat (step) tick();
      cnt = int'(exp_code) + 10;
      if (cnt > 101) begin
        exp_code = exp_code - 8'd1; exp_lock = 1'b0;
      end else if (cnt < 99) begin
        exp_code = exp_code + 8'd1; exp_lock = 1'b0;
      end else begin
        exp_lock = 1'b1;
      end
      checks++;
      if (bus.dco_code !== exp_code) begin
        errors++; $display("FAIL track_step%0d_code: got %h expected %h", j, bus.dco_code, exp_code);
      end
      checks++;
      if (bus.locked !== exp_lock) begin
        errors++; $display("FAIL track_step%0d_lock: got %b expected %b", j, bus.locked, exp_lock);
      end
    end
    bus.track_en = 1'b0;
    repeat (step) tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL track_exit_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++; $display("FAIL track_exit_lock: got %b expected 1", bus.locked);
    end
    checks++;
    if (bus.dco_code !== 8'h5B) begin
      errors++; $display("FAIL track_exit_code: got %h expected 5b", bus.dco_code);
    end
  endtask

  task automatic run_sat(input string tag, input int target, input int tolv, input int offs,
                         input logic [7:0] exp_code);
    int step;
    step = SettleCyc + 512 + 1;
    configure(512, target, tolv, 1'b1, offs);
    apply_reset();
    pulse_start();
    repeat (8 * step - 1) tick();
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL %s_done: got %b expected 1", tag, bus.done);
    end
    tick();
    checks++;
    if (bus.dco_code !== exp_code) begin
      errors++; $display("FAIL %s_sar_code: got %h expected %h", tag, bus.dco_code, exp_code);
    end
    checks++;
    if (bus.sat !== 1'b0) begin
      errors++; $display("FAIL %s_sat_before: got %b expected 0", tag, bus.sat);
    end
    for (int j = 1; j <= 2; j++) begin
      repeat (step) tick();
      checks++;
      if (bus.sat !== 1'b1) begin
        errors++; $display("FAIL %s_sat%0d: got %b expected 1", tag, j, bus.sat);
      end
      checks++;
      if (bus.dco_code !== exp_code) begin
        errors++; $display("FAIL %s_hold%0d: got %h expected %h", tag, j, bus.dco_code, exp_code);
      end
      checks++;
      if (bus.locked !== 1'b0) begin
        errors++; $display("FAIL %s_locked%0d: got %b expected 0", tag, j, bus.locked);
      end
    end
  endtask

  task automatic test_sat_high();
    run_sat("sat_high", 300, 1, 0, 8'hFF);
  endtask

  // A floor offset of one edge keeps the count above zero even at code 0.
  task automatic test_sat_low();
    run_sat("sat_low", 0, 0, 1, 8'h00);
  endtask

  task automatic test_control_edges();
    configure(512, 100, 1, 1'b0, 0);
    apply_reset();
    run_sar("start_ignored", 512, 100);
    pulse_start();
    repeat (199) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.dco_code !== 8'h00) begin
      errors++; $display("FAIL midreset_code: got %h expected 00", bus.dco_code);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL midreset_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL midreset_done: got %b expected 0", bus.done);
    end
    checks++;
    if (bus.meas_cnt !== 16'd0) begin
      errors++; $display("FAIL midreset_meas: got %0d expected 0", bus.meas_cnt);
    end
    rst = 1'b0;
    tick();
    run_sar("after_reset", 512, 0);
  endtask

  initial begin
    sar_trial = '{8'h80, 8'h40, 8'h60, 8'h70, 8'h68, 8'h64, 8'h66, 8'h65};
    test_reset();
    test_sar_only();
    test_tracking();
    test_sat_high();
    test_sat_low();
    test_control_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
